imm_gen_pipe: RTL and testbench

- Two-stage pipelined immediate generator for the decode path.
- Covers all RV32I/RV64I immediate formats: I, S, B, U and J.
- Stage 1 classifies the format from the opcode. Stage 2 assembles the immediate and sign-extends it to XLEN.
- Sits between fetch/IF-ID and the register-read/ALU operand mux. Uses a valid/ready handshake on both sides, plus flush and an illegal-opcode counter.

---
 rtl/imm_gen_pipe_if.sv | 30 +++
 rtl/imm_gen_pipe.sv | 140 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake and result bundle between the decode front end and the
// immediate generator. The master side is the producer/consumer pair
// around the block and the slave side is the generator itself.
interface imm_gen_pipe_if #(
  parameter int INSTRUCTION = 32,
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTRUCTION-1:0] instruction;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTRUCTION-1:0] out_instr;
  logic [XLEN-1:0]        imme;
  logic [2:0]             fmt;
  logic                   illegal;
  logic [CNT_W-1:0]       illegal_cnt;

  modport master (
    output flush, in_valid, instruction, out_ready,
    input  in_ready, out_valid, out_instr, imme, fmt, illegal, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, instruction, out_ready,
    output in_ready, out_valid, out_instr, imme, fmt, illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator for the decode path.
// Stage 1 latches the instruction and its format class (from the opcode);
// stage 2 holds the assembled, sign-extended immediate for the operand mux.
// Both stages use a valid/ready pipeline where a stage may load whenever it
// is empty or its content is leaving in the same cycle.
module imm_gen_pipe #(
  parameter int INSTRUCTION = 32,
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Opcode to format class. The W-variants only exist on a 64-bit datapath.
  function automatic fmt_e classify(input logic [6:0] op);
    fmt_e f;
    f = FMT_ILL;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:             f = FMT_I;
      7'b0100011:                         f = FMT_S;
      7'b1100011:                         f = FMT_B;
      7'b0110111, 7'b0010111:             f = FMT_U;
      7'b1101111:                         f = FMT_J;
      7'b0110011:                         f = FMT_R;
      7'b0011011: if (XLEN == 64)         f = FMT_I;
      7'b0111011: if (XLEN == 64)         f = FMT_R;
      default:                            f = FMT_ILL;
    endcase
    return f;
  endfunction

  logic                   s1_valid;
  logic [INSTRUCTION-1:0] s1_instr;
  fmt_e                   s1_fmt;

  logic                   s2_valid;
  logic [INSTRUCTION-1:0] s2_instr;
  fmt_e                   s2_fmt;
  logic [XLEN-1:0]        s2_imme;
  logic                   s2_illegal;

  logic [CNT_W-1:0]       ill_cnt;

  logic                   adv1;
  logic                   adv2;
  logic                   out_xfer;
  logic [31:0]            imm32;
  logic [XLEN-1:0]        imm_s1;

  assign adv2     = !s2_valid || bus.out_ready;
  assign adv1     = !s1_valid || adv2;
  assign out_xfer = s2_valid && bus.out_ready;

  assign bus.in_ready    = adv1 && !bus.flush;
  assign bus.out_valid   = s2_valid;
  assign bus.out_instr   = s2_instr;
  assign bus.imme        = s2_imme;
  assign bus.fmt         = s2_fmt;
  assign bus.illegal     = s2_illegal;
  assign bus.illegal_cnt = ill_cnt;

  // Assemble the 32-bit immediate of the stage-1 instruction; R and illegal yield zero.
  always_comb begin
    imm32 = '0;
    case (s1_fmt)
      FMT_I:   imm32 = {{20{s1_instr[31]}}, s1_instr[31:20]};
      FMT_S:   imm32 = {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
      FMT_B:   imm32 = {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                        s1_instr[30:25], s1_instr[11:8], 1'b0};
      FMT_U:   imm32 = {s1_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                        s1_instr[20], s1_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Bit 31 of every assembled form is the instruction sign bit, so widening is a plain sign extension.
  assign imm_s1 = XLEN'($signed(imm32));

  // Stage 1: capture instruction and classify its opcode; flush empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_fmt   <= FMT_R;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_instr <= bus.instruction;
        s1_fmt   <= classify(bus.instruction[6:0]);
      end
    end
  end

  // Stage 2: register the result; data only changes when a new entry moves in, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_instr   <= '0;
      s2_fmt     <= FMT_R;
      s2_imme    <= '0;
      s2_illegal <= 1'b0;
    end else if (bus.flush) begin
      s2_valid <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr   <= s1_instr;
        s2_fmt     <= s1_fmt;
        s2_imme    <= imm_s1;
        s2_illegal <= (s1_fmt == FMT_ILL);
      end
    end
  end

  // Saturating count of illegal results delivered; an entry dropped by flush is never delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (!bus.flush && out_xfer && s2_illegal && (ill_cnt != {CNT_W{1'b1}})) begin
      ill_cnt <= ill_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.INSTRUCTION(32), .XLEN(32), .CNT_W(16)) bus ();
  imm_gen_pipe_if #(.INSTRUCTION(32), .XLEN(64), .CNT_W(2))  bus64 ();

  imm_gen_pipe #(.INSTRUCTION(32), .XLEN(32), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  imm_gen_pipe #(.INSTRUCTION(32), .XLEN(64), .CNT_W(2)) dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus64.slave)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[16];

  int tests = 0;
  int fails = 0;

  logic [31:0] s_ins[8];
  logic [31:0] s_imm[8];
  logic [2:0]  s_fmt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single instruction through an empty pipe, measuring latency and checking the result.
  task automatic send1(input string nm, input logic [31:0] ins, input logic [31:0] imm,
                       input logic [2:0] fmt, input logic ill);
    int lat;
    bus.instruction = ins;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    #1;
    check({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'd2);
    check({nm, " imme"}, 64'(bus.imme), 64'(imm));
    check({nm, " fmt"}, 64'(bus.fmt), 64'(fmt));
    check({nm, " illegal"}, 64'(bus.illegal), 64'(ill));
    check({nm, " out_instr"}, 64'(bus.out_instr), 64'(ins));
    step();
  endtask

  task automatic send64(input string nm, input logic [31:0] ins, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
    int lat;
    bus64.instruction = ins;
    bus64.in_valid    = 1'b1;
    bus64.out_ready   = 1'b1;
    step();
    bus64.in_valid = 1'b0;
    lat = 1;
    while (!bus64.out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'd2);
    check({nm, " imme"}, bus64.imme, imm);
    check({nm, " fmt"}, 64'(bus64.fmt), 64'(fmt));
    check({nm, " illegal"}, 64'(bus64.illegal), 64'(ill));
    step();
  endtask

  // Stream n entries from s_ins; out_ready is held low for the first 'hold' cycles.
  task automatic stream(input string tag, input int n, input int hold,
                        output int stall, output int first, output int last);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    stall = 0;
    first = -1;
    last  = -1;
    while (got < n && cyc < 60) begin
      bus.in_valid    = (sent < n);
      bus.instruction = (sent < n) ? s_ins[sent] : 32'h0;
      bus.out_ready   = (cyc >= hold);
      #1;
      if (bus.in_valid && !bus.in_ready) stall++;
      if (bus.out_valid && !bus.out_ready) begin
        check($sformatf("%s held instr %0d", tag, got), 64'(bus.out_instr), 64'(s_ins[got]));
        check($sformatf("%s held imme %0d", tag, got), 64'(bus.imme), 64'(s_imm[got]));
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("%s instr %0d", tag, got), 64'(bus.out_instr), 64'(s_ins[got]));
        check($sformatf("%s imme %0d", tag, got), 64'(bus.imme), 64'(s_imm[got]));
        check($sformatf("%s fmt %0d", tag, got), 64'(bus.fmt), 64'(s_fmt[got]));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, " results delivered"}, 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall, first, last, seen;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h00412083, 32'h00000004, 3'd1, 1'b0};
    vecs[2]  = '{32'hFFC08067, 32'hFFFFFFFC, 3'd1, 1'b0};
    vecs[3]  = '{32'h00000073, 32'h00000000, 3'd1, 1'b0};
    vecs[4]  = '{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0};
    vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[6]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
    vecs[7]  = '{32'h00208463, 32'h00000008, 3'd3, 1'b0};
    vecs[8]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
    vecs[9]  = '{32'hFFFFF0B7, 32'hFFFFF000, 3'd4, 1'b0};
    vecs[10] = '{32'h80000017, 32'h80000000, 3'd4, 1'b0};
    vecs[11] = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
    vecs[12] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0};
    vecs[13] = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0};
    vecs[14] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
    vecs[15] = '{32'h0011B01B, 32'h00000000, 3'd7, 1'b1};

    bus.flush = 1'b0;   bus.in_valid = 1'b0;   bus.instruction = '0;   bus.out_ready = 1'b1;
    bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.instruction = '0; bus64.out_ready = 1'b1;

    // reset
    rst_n = 1'b0;
    repeat (3) step();
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst imme", 64'(bus.imme), 64'd0);
    check("rst fmt", 64'(bus.fmt), 64'd0);
    check("rst illegal", 64'(bus.illegal), 64'd0);
    check("rst out_instr", 64'(bus.out_instr), 64'd0);
    check("rst illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    check("rst64 imme", bus64.imme, 64'd0);
    rst_n = 1'b1;
    step();

    // table of single-instruction vectors
    for (int i = 0; i < 16; i++) begin
      send1($sformatf("vec%0d", i), vecs[i].ins, vecs[i].imm, vecs[i].fmt, vecs[i].ill);
    end

    // back-to-back S, B, U, J at full rate
    s_ins[0] = 32'hFE112E23; s_imm[0] = 32'hFFFFFFFC; s_fmt[0] = 3'd2;
    s_ins[1] = 32'hFE000CE3; s_imm[1] = 32'hFFFFFFF8; s_fmt[1] = 3'd3;
    s_ins[2] = 32'h123450B7; s_imm[2] = 32'h12345000; s_fmt[2] = 3'd4;
    s_ins[3] = 32'h001000EF; s_imm[3] = 32'h00000800; s_fmt[3] = 3'd5;
    stream("b2b", 4, 0, stall, first, last);
    check("b2b stalls", 64'(stall), 64'd0);
    check("b2b first out cycle", 64'(first), 64'd2);
    check("b2b last out cycle", 64'(last), 64'd5);

    // backpressure: out_ready low for the first 4 cycles
    s_ins[0] = 32'hFFF00093; s_imm[0] = 32'hFFFFFFFF; s_fmt[0] = 3'd1;
    s_ins[1] = 32'h00208463; s_imm[1] = 32'h00000008; s_fmt[1] = 3'd3;
    s_ins[2] = 32'h002081B3; s_imm[2] = 32'h00000000; s_fmt[2] = 3'd0;
    s_ins[3] = 32'hFFDFF0EF; s_imm[3] = 32'hFFFFFFFC; s_fmt[3] = 3'd5;
    stream("bp", 4, 4, stall, first, last);
    check("bp stall cycles", 64'(stall), 64'd2);
    check("bp first out cycle", 64'(first), 64'd4);
    check("bp last out cycle", 64'(last), 64'd7);
    bus.out_ready = 1'b1;
    step();

    // flush drops the in-flight R-type; nothing accepted during flush
    bus.instruction = 32'h002081B3;
    bus.in_valid    = 1'b1;
    step();
    bus.flush       = 1'b1;
    bus.instruction = 32'h00412083;
    #1;
    check("flush in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("flush no output", 64'(seen), 64'd0);
    send1("post-flush", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);

    // reset while an entry is in flight discards it and clears the counter
    bus.instruction = 32'h0000007F;
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async rst out_valid", 64'(bus.out_valid), 64'd0);
    check("async rst illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (3) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("rst discards in-flight", 64'(seen), 64'd0);

    // illegal counter
    for (int i = 0; i < 3; i++) begin
      send1($sformatf("ill%0d", i), 32'h0000007F, 32'h0, 3'd7, 1'b1);
    end
    check("illegal_cnt 3", 64'(bus.illegal_cnt), 64'd3);
    bus.instruction = 32'h0000007F;
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (3) step();
    check("illegal_cnt after flush", 64'(bus.illegal_cnt), 64'd3);

    // 64-bit datapath and 2-bit saturating counter
    send64("x64 lui", 32'hFFFFF0B7, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0);
    send64("x64 addi", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send64("x64 addiw", 32'h0011B01B, 64'h0000000000000001, 3'd1, 1'b0);
    send64("x64 addw", 32'h0000003B, 64'h0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send64($sformatf("x64 ill%0d", i), 32'h0000007F, 64'h0, 3'd7, 1'b1);
    end
    check("x64 illegal_cnt 3", 64'(bus64.illegal_cnt), 64'd3);
    for (int i = 3; i < 5; i++) begin
      send64($sformatf("x64 ill%0d", i), 32'h0000007F, 64'h0, 3'd7, 1'b1);
    end
    check("x64 illegal_cnt saturated", 64'(bus64.illegal_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
